// File: rtl/stage_memory.sv
// Memory stage of the vector pipeline. PASS/reserved ops forward the execute
// result in one cycle; LOAD/STORE walk the vector one lane at a time over a
// single-lane memory port, stalling upstream until the whole vector is done.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | accepting instructions; PASS results forwarded directly
// ACCESS | one lane request outstanding, held until mem_ack
// DONE   | all lanes finished; publish result, return to IDLE
module stage_memory #(
  parameter int vectorSize   = 4,
  parameter int registerSize = 8,
  parameter int addrSize     = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     valid_in,
  input  logic [1:0]                               MemOp,
  input  logic [addrSize-1:0]                      addr_in,
  input  logic [vectorSize-1:0][registerSize-1:0]  alu_in,
  input  logic [vectorSize-1:0][registerSize-1:0]  store_data,
  output logic                                     mem_req,
  output logic                                     mem_we,
  output logic [addrSize-1:0]                      mem_addr,
  output logic [registerSize-1:0]                  mem_wdata,
  input  logic [registerSize-1:0]                  mem_rdata,
  input  logic                                     mem_ack,
  output logic                                     stall,
  output logic                                     valid_out,
  output logic [vectorSize-1:0][registerSize-1:0]  vect_out
);

  // A one-lane vector still needs a 1-bit counter to be a legal vector.
  localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(vectorSize - 1);
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                                   state;
  logic [LW-1:0]                            lane;
  logic [LW-1:0]                            lane_nxt;
  logic                                     is_store;
  logic [addrSize-1:0]                      base_q;
  logic [vectorSize-1:0][registerSize-1:0]  sdata_q;
  logic [vectorSize-1:0][registerSize-1:0]  buf_q;

  assign lane_nxt = lane + LW'(1);
  assign stall    = (state != IDLE);

  // Sequencer: accepts instructions, issues one lane per ack, publishes result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lane      <= '0;
      is_store  <= 1'b0;
      base_q    <= '0;
      sdata_q   <= '0;
      buf_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid_out <= 1'b0;
      vect_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (MemOp == OP_LOAD || MemOp == OP_STORE) begin
              base_q    <= addr_in;
              sdata_q   <= store_data;
              is_store  <= (MemOp == OP_STORE);
              lane      <= '0;
              buf_q     <= '0;
              state     <= ACCESS;
              // First beat is presented straight away so lane 0 can be acked
              // on the very next edge.
              mem_req   <= 1'b1;
              mem_we    <= (MemOp == OP_STORE);
              mem_addr  <= addr_in;
              mem_wdata <= (MemOp == OP_STORE) ? store_data[0] : '0;
            end else begin
              vect_out  <= alu_in;
              valid_out <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!is_store) buf_q[lane] <= mem_rdata;
            if (lane == LAST_LANE) begin
              lane      <= '0;
              state     <= DONE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
            end else begin
              lane      <= lane_nxt;
              mem_addr  <= base_q + addrSize'(lane_nxt);
              mem_wdata <= is_store ? sdata_q[lane_nxt] : '0;
            end
          end
        end
        DONE: begin
          valid_out <= 1'b1;
          vect_out  <= is_store ? '0 : buf_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Randomised bench for stage_memory: a lane-level memory responder driven
// from a transaction model that knows only the addressing and result rules.
module tb_stage_memory;

  typedef logic [3:0][7:0] vec_t;
  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  MemOp = 2'b00;
  logic [15:0] addr_in = '0;
  vec_t        alu_in = '0;
  vec_t        store_data = '0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        valid_out;
  vec_t        vect_out;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem_model [logic [15:0]];

  stage_memory #(.vectorSize(4), .registerSize(8), .addrSize(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .MemOp(MemOp),
    .addr_in(addr_in), .alu_in(alu_in), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .valid_out(valid_out), .vect_out(vect_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
    return mem_model[a];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
  endtask

  // One instruction end to end; lane ack delay drawn from [mind, maxd].
  task automatic run_txn(input logic [1:0] op, input logic [15:0] base,
                         input vec_t alu, input vec_t sd,
                         input int mind, input int maxd, input bit noise);
    vec_t        exp_v;
    logic [15:0] a;
    int          d;
    @(negedge clk);
    valid_in   = 1'b1;
    MemOp      = op;
    addr_in    = base;
    alu_in     = alu;
    store_data = sd;
    mem_ack    = noise ? 1'($urandom) : 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (op == OP_LOAD || op == OP_STORE) begin
      exp_v = '0;
      for (int i = 0; i < 4; i++) begin
        a = base + 16'(i);
        d = $urandom_range(mind, maxd);
        for (int w = 0; w <= d; w++) begin
          @(negedge clk);
          chk("beat_stall", stall, 1'b1);
          chk("beat_req", mem_req, 1'b1);
          chk("beat_addr", mem_addr, a);
          chk("beat_we", mem_we, op == OP_STORE);
          chk("beat_wdata", mem_wdata, (op == OP_STORE) ? sd[i] : 8'h00);
          chk("beat_valid_out", valid_out, 1'b0);
          if (noise) begin
            valid_in   = 1'($urandom);
            MemOp      = 2'($urandom);
            alu_in     = vec_t'($urandom);
            addr_in    = 16'($urandom);
            store_data = vec_t'($urandom);
          end
          if (w == d) begin
            mem_ack = 1'b1;
            if (op == OP_STORE) mem_model[a] = sd[i];
            else begin
              exp_v[i]  = mem_rd(a);
              mem_rdata = exp_v[i];
            end
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
          end
        end
      end
      @(negedge clk);
      mem_ack = noise ? 1'($urandom) : 1'b0;
      chk("done_stall", stall, 1'b1);
      chk("done_req", mem_req, 1'b0);
      chk("done_valid_out", valid_out, 1'b0);
      @(negedge clk);
      valid_in = 1'b0;
      chk("res_valid_out", valid_out, 1'b1);
      chk("res_vect_out", vect_out, exp_v);
      chk_idle_outputs("res");
    end else begin
      exp_v = alu;
      @(negedge clk);
      chk("pass_valid_out", valid_out, 1'b1);
      chk("pass_vect_out", vect_out, exp_v);
      chk_idle_outputs("pass");
    end
    mem_ack = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("after_valid_out", valid_out, 1'b0);
    chk("after_vect_hold", vect_out, exp_v);
    chk_idle_outputs("after");
  endtask

  initial begin
    vec_t        v;
    vec_t        s;
    logic [1:0]  op;
    logic [15:0] base;

    #2;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_vect_out", vect_out, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 8'h0);
    chk("rst_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed: forwarding path
    run_txn(OP_PASS, 16'h0, {8'h3C, 8'h3C, 8'hFF, 8'hFF}, '0, 0, 0, 1'b0);

    // Directed: load with ack every cycle
    mem_model[16'h0010] = 8'h2D;
    mem_model[16'h0011] = 8'h00;
    mem_model[16'h0012] = 8'h32;
    mem_model[16'h0013] = 8'h32;
    run_txn(OP_LOAD, 16'h0010, '0, '0, 0, 0, 1'b0);

    // Directed: store with two wait cycles per lane
    s = '0;
    s[0] = 8'h01; s[1] = 8'h02; s[2] = 8'h03; s[3] = 8'h04;
    run_txn(OP_STORE, 16'h0020, '0, s, 2, 2, 1'b0);

    // Directed: address wrap, then read back the stored vector
    run_txn(OP_LOAD, 16'hFFFE, '0, '0, 0, 1, 1'b0);
    run_txn(OP_LOAD, 16'h0020, '0, '0, 0, 0, 1'b0);

    // Directed: upstream keeps pulsing during a stall
    run_txn(OP_LOAD, 16'h0100, '0, '0, 1, 2, 1'b1);

    // Random mix
    for (int t = 0; t < 40; t++) begin
      op   = 2'($urandom);
      base = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                         : 16'($urandom_range(0, 63));
      v    = vec_t'($urandom);
      s    = vec_t'($urandom);
      run_txn(op, base, v, s, 0, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset during lane 2 of a store
    run_txn(OP_PASS, 16'h0, 32'hA5C3_5A3C, '0, 0, 0, 1'b0);
    @(negedge clk);
    valid_in   = 1'b1;
    MemOp      = OP_STORE;
    addr_in    = 16'h0040;
    store_data = 32'h4433_2211;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lane2_addr", mem_addr, 16'h0042);
    chk("lane2_req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_we", mem_we, 1'b0);
    chk("mid_rst_addr", mem_addr, 16'h0);
    chk("mid_rst_wdata", mem_wdata, 8'h0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_valid_out", valid_out, 1'b0);
    chk("mid_rst_vect_out", vect_out, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      chk("post_rst_req", mem_req, 1'b0);
      chk("post_rst_valid_out", valid_out, 1'b0);
    end
    mem_ack = 1'b0;
    run_txn(OP_PASS, 16'h0, 32'h1234_5678, '0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
